// File: rtl/dest_pipeline_tracker_pkg.sv
// -----------------------------------------------------------------------------
// dest_pipeline_tracker_pkg
// Shared definitions for the destination-register pipeline tracker.
//   REG_W   : architectural register index width
//   G0      : hard-wired zero register (%g0); writes to it are discarded
//   stage_t : one pipeline-stage entry {rd, we, ld}
// -----------------------------------------------------------------------------
package dest_pipeline_tracker_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] G0 = 5'd0;

  typedef struct packed {
    logic [REG_W-1:0] rd;  // destination register
    logic             we;  // stage holds a valid register-file write
    logic             ld;  // stage holds a load
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{rd: G0, we: 1'b0, ld: 1'b0};

endpackage : dest_pipeline_tracker_pkg

// File: rtl/dest_stage_reg.sv
// -----------------------------------------------------------------------------
// dest_stage_reg
// One pipeline-stage register with asynchronous clear and a bubble select.
// Optional feature macro: LOAD_USE_STALL_EN (when undefined the load flag is
// not stored and q.ld reads constant 0).
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low clear
//   bubble : load an empty entry instead of d
//   d      : incoming stage entry
//   q      : registered stage entry
// -----------------------------------------------------------------------------
module dest_stage_reg
  import dest_pipeline_tracker_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  logic [REG_W-1:0] rd_q;
  logic             we_q;

  // NOTE: sequential state uses non-blocking (<=) so every stage samples the
  // pre-edge value of its neighbour; blocking here would collapse the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these are flops, not a memory array, so they are cleared
      // asynchronously; the outputs must read zero while rst_n is low.
      rd_q <= G0;
      we_q <= 1'b0;
    end else if (bubble) begin
      rd_q <= G0;
      we_q <= 1'b0;
    end else begin
      rd_q <= d.rd;
      we_q <= d.we;
    end
  end

`ifdef LOAD_USE_STALL_EN
  logic ld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ld_q <= 1'b0;
    else if (bubble) ld_q <= 1'b0;
    else             ld_q <= d.ld;
  end

  assign q = '{rd: rd_q, we: we_q, ld: ld_q};
`else
  // Load flag is not tracked in this build.
  logic unused_ld;
  assign unused_ld = d.ld;
  assign q = '{rd: rd_q, we: we_q, ld: 1'b0};
`endif

endmodule : dest_stage_reg

// File: rtl/dest_pipeline_tracker.sv
// -----------------------------------------------------------------------------
// dest_pipeline_tracker
// Tracks the destination register, write-enable and load flag of the
// instructions in EX, MEM and WB, counts valid in-flight writes and raises a
// load-use stall request.
// Optional feature macro: LOAD_USE_STALL_EN. When undefined, EX_load_instr and
// load_use_stall are constant 0 and no load flag is stored.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   ID_RD, ID_Register_File_Enable,
//   ID_load_instr                   : destination info of the ID instruction
//   ID_rs1, ID_rs2                  : ID source registers (hazard compare)
//   CU_S                            : hazard-unit bubble request into EX
//   flush                           : annul the ID instruction
//   EX_/MEM_/WB_RD, *_Enable        : per-stage destination and write-valid
//   EX_load_instr                   : EX instruction is a load
//   load_use_stall                  : combinational load-use stall request
//   inflight_count                  : registered count of valid stage writes
// -----------------------------------------------------------------------------
module dest_pipeline_tracker
  import dest_pipeline_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ID_RD,
  input  logic             ID_Register_File_Enable,
  input  logic             ID_load_instr,
  input  logic [REG_W-1:0] ID_rs1,
  input  logic [REG_W-1:0] ID_rs2,
  input  logic             CU_S,
  input  logic             flush,
  output logic [REG_W-1:0] EX_RD,
  output logic [REG_W-1:0] MEM_RD,
  output logic [REG_W-1:0] WB_RD,
  output logic             EX_Register_File_Enable,
  output logic             MEM_Register_File_Enable,
  output logic             WB_Register_File_Enable,
  output logic             EX_load_instr,
  output logic             load_use_stall,
  output logic [1:0]       inflight_count
);

  stage_t ex_d;
  stage_t ex_q;
  stage_t mem_q;
  stage_t wb_q;
  logic   ex_bubble;
  logic   ex_we_next;

  // CU_S and flush collapse into one bubble; both together still cost a
  // single slot.
  assign ex_bubble = CU_S | flush;

  // NOTE: every always_comb target gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    ex_d    = STAGE_BUBBLE;
    ex_d.rd = ID_RD;
    ex_d.ld = ID_load_instr;
    ex_d.we = ID_Register_File_Enable;
    // A write to %g0 is architecturally a no-op: drop the enable and rd.
    if (ID_RD == G0) begin
      ex_d.rd = G0;
      ex_d.we = 1'b0;
    end
  end

  dest_stage_reg u_ex (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (ex_bubble),
    .d      (ex_d),
    .q      (ex_q)
  );

  // MEM and WB always advance; the tracker never holds its own shift.
  dest_stage_reg u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  dest_stage_reg u_wb (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  // Count is taken from the next-state enables so it lines up with the stage
  // registers after the same edge.
  assign ex_we_next = ex_d.we & ~ex_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_count <= 2'd0;
    else        inflight_count <= {1'b0, ex_we_next} + {1'b0, ex_q.we}
                                + {1'b0, mem_q.we};
  end

  assign EX_RD                    = ex_q.rd;
  assign MEM_RD                   = mem_q.rd;
  assign WB_RD                    = wb_q.rd;
  assign EX_Register_File_Enable  = ex_q.we;
  assign MEM_Register_File_Enable = mem_q.we;
  assign WB_Register_File_Enable  = wb_q.we;

`ifdef LOAD_USE_STALL_EN
  assign EX_load_instr  = ex_q.ld;
  assign load_use_stall = ex_q.ld & ex_q.we & (ex_q.rd != G0)
                        & ((ID_rs1 == ex_q.rd) | (ID_rs2 == ex_q.rd));

  // Load flags past EX are carried only to keep the stage entry uniform.
  logic unused_ld;
  assign unused_ld = mem_q.ld ^ wb_q.ld;
`else
  assign EX_load_instr  = 1'b0;
  assign load_use_stall = 1'b0;

  logic unused_hazard;
  assign unused_hazard = ^{ID_rs1, ID_rs2, ex_q.ld, mem_q.ld, wb_q.ld};
`endif

endmodule : dest_pipeline_tracker

// File: tb/tb_dest_pipeline_tracker.sv
// -----------------------------------------------------------------------------
// tb_dest_pipeline_tracker
// Self-checking bench for dest_pipeline_tracker. A reference model holds the
// three stage entries as plain arrays, advanced once per rising edge from the
// behavioural rules; directed scenarios add fixed expected values.
// -----------------------------------------------------------------------------
module tb_dest_pipeline_tracker;

`ifdef LOAD_USE_STALL_EN
  localparam bit LD_ON = 1'b1;
`else
  localparam bit LD_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [4:0] ID_RD;
  logic       ID_Register_File_Enable;
  logic       ID_load_instr;
  logic [4:0] ID_rs1;
  logic [4:0] ID_rs2;
  logic       CU_S;
  logic       flush;
  logic [4:0] EX_RD, MEM_RD, WB_RD;
  logic       EX_Register_File_Enable, MEM_Register_File_Enable;
  logic       WB_Register_File_Enable;
  logic       EX_load_instr;
  logic       load_use_stall;
  logic [1:0] inflight_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: index 0 = EX, 1 = MEM, 2 = WB.
  logic [4:0] m_rd [3];
  bit         m_we [3];
  bit         m_ld [3];

  dest_pipeline_tracker dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .ID_RD                    (ID_RD),
    .ID_Register_File_Enable  (ID_Register_File_Enable),
    .ID_load_instr            (ID_load_instr),
    .ID_rs1                   (ID_rs1),
    .ID_rs2                   (ID_rs2),
    .CU_S                     (CU_S),
    .flush                    (flush),
    .EX_RD                    (EX_RD),
    .MEM_RD                   (MEM_RD),
    .WB_RD                    (WB_RD),
    .EX_Register_File_Enable  (EX_Register_File_Enable),
    .MEM_Register_File_Enable (MEM_Register_File_Enable),
    .WB_Register_File_Enable  (WB_Register_File_Enable),
    .EX_load_instr            (EX_load_instr),
    .load_use_stall           (load_use_stall),
    .inflight_count           (inflight_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [21:0] obs_vec();
    return {EX_RD, EX_Register_File_Enable, EX_load_instr,
            MEM_RD, MEM_Register_File_Enable,
            WB_RD, WB_Register_File_Enable,
            inflight_count, load_use_stall};
  endfunction

  function automatic logic [21:0] exp_vec();
    int  cnt;
    bit  stall;
    cnt   = int'(m_we[0]) + int'(m_we[1]) + int'(m_we[2]);
    stall = LD_ON && m_ld[0] && m_we[0] && (m_rd[0] != 5'd0) &&
            ((ID_rs1 == m_rd[0]) || (ID_rs2 == m_rd[0]));
    return {m_rd[0], m_we[0], m_ld[0], m_rd[1], m_we[1], m_rd[2], m_we[2],
            2'(cnt), stall};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_rd[i] = 5'd0;
      m_we[i] = 1'b0;
      m_ld[i] = 1'b0;
    end
  endtask

  // One rising edge: the model consumes the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    for (int i = 2; i > 0; i--) begin
      m_rd[i] = m_rd[i-1];
      m_we[i] = m_we[i-1];
      m_ld[i] = m_ld[i-1];
    end
    if (CU_S || flush || !rst_n) begin
      m_rd[0] = 5'd0;
      m_we[0] = 1'b0;
      m_ld[0] = 1'b0;
    end else begin
      m_we[0] = ID_Register_File_Enable && (ID_RD != 5'd0);
      m_rd[0] = (ID_RD != 5'd0) ? ID_RD : 5'd0;
      m_ld[0] = LD_ON && ID_load_instr;
    end
    #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic we, input logic ld,
                       input logic s, input logic f);
    ID_RD = rd; ID_Register_File_Enable = we; ID_load_instr = ld;
    CU_S = s; flush = f;
  endtask

  task automatic test_reset();
    drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ID_rs1 = 5'd0; ID_rs2 = 5'd0;
    rst_n = 1'b0;
    model_clear();
    #23;
    n_checks++;
    if (obs_vec() !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", obs_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    // First edge after deassertion captures ID normally.
    drive(5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (EX_RD !== 5'd12 || EX_Register_File_Enable !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_capture: got rd=%0d we=%0b expected rd=12 we=1",
               EX_RD, EX_Register_File_Enable);
    end
    drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_propagation();
    logic [1:0] exp_cnt [4];
    exp_cnt = '{2'd1, 2'd1, 2'd1, 2'd0};
    drive(5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (EX_RD !== 5'd9) begin
      n_fail++; $display("FAIL prop_ex: EX_RD got %0d expected 9", EX_RD);
    end
    drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int e = 0; e < 4; e++) begin
      if (e > 0) tick();
      n_checks++;
      if (inflight_count !== exp_cnt[e]) begin
        n_fail++;
        $display("FAIL prop_count_edge%0d: got %0d expected %0d",
                 e + 1, inflight_count, exp_cnt[e]);
      end
      if (e == 1) begin
        n_checks++;
        if (MEM_RD !== 5'd9) begin
          n_fail++; $display("FAIL prop_mem: MEM_RD got %0d expected 9", MEM_RD);
        end
      end
      if (e == 2) begin
        n_checks++;
        if (WB_RD !== 5'd9 || WB_Register_File_Enable !== 1'b1) begin
          n_fail++;
          $display("FAIL prop_wb: WB_RD got %0d we=%0b expected 9 we=1",
                   WB_RD, WB_Register_File_Enable);
        end
      end
    end
  endtask

  task automatic test_g0();
    repeat (3) tick();
    drive(5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (EX_Register_File_Enable !== 1'b0 || EX_RD !== 5'd0 ||
        inflight_count !== 2'd0) begin
      n_fail++;
      $display("FAIL g0_write: got we=%0b rd=%0d cnt=%0d expected 0 0 0",
               EX_Register_File_Enable, EX_RD, inflight_count);
    end
  endtask

  task automatic test_bubble();
    drive(5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (EX_RD !== 5'd0 || EX_Register_File_Enable !== 1'b0 ||
        MEM_RD !== 5'd5 || MEM_Register_File_Enable !== 1'b1) begin
      n_fail++;
      $display("FAIL bubble: got ex=%0d/%0b mem=%0d/%0b expected 0/0 5/1",
               EX_RD, EX_Register_File_Enable, MEM_RD, MEM_Register_File_Enable);
    end
    // Next edge resumes with no extra lost slot.
    drive(5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (EX_RD !== 5'd4 || WB_RD !== 5'd5 || inflight_count !== 2'd2) begin
      n_fail++;
      $display("FAIL bubble_resume: got ex=%0d wb=%0d cnt=%0d expected 4 5 2",
               EX_RD, WB_RD, inflight_count);
    end
  endtask

  task automatic test_load_use();
    drive(5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ID_rs1 = 5'd0; ID_rs2 = 5'd7;
    #1;
    n_checks++;
    if (load_use_stall !== LD_ON || EX_load_instr !== LD_ON) begin
      n_fail++;
      $display("FAIL load_use_hit: got stall=%0b ld=%0b expected %0b",
               load_use_stall, EX_load_instr, LD_ON);
    end
    ID_rs1 = 5'd6; ID_rs2 = 5'd6;
    #1;
    n_checks++;
    if (load_use_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_miss: got stall=%0b expected 0", load_use_stall);
    end
    ID_rs1 = 5'd7;
    #1;
    n_checks++;
    if (load_use_stall !== LD_ON) begin
      n_fail++;
      $display("FAIL load_use_rs1: got stall=%0b expected %0b",
               load_use_stall, LD_ON);
    end
    ID_rs1 = 5'd0; ID_rs2 = 5'd0;
  endtask

  task automatic test_back_to_back();
    drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    for (int r = 1; r <= 3; r++) begin
      drive(5'(r), 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    n_checks++;
    if (EX_RD !== 5'd3 || MEM_RD !== 5'd2 || WB_RD !== 5'd1 ||
        inflight_count !== 2'd3) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d/%0d/%0d cnt=%0d expected 3/2/1 cnt=3",
               EX_RD, MEM_RD, WB_RD, inflight_count);
    end
    drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 300; c++) begin
      drive(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
            1'($urandom), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 6) == 0));
      ID_rs1 = 5'($urandom_range(0, 31));
      ID_rs2 = (c % 4 == 0) ? m_rd[0] : 5'($urandom_range(0, 31));
      #1;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; errs++;
        if (errs < 10)
          $display("FAIL random_comb cyc%0d: got %h expected %h",
                   c, obs_vec(), exp_vec());
      end
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; errs++;
        if (errs < 10)
          $display("FAIL random_edge cyc%0d: got %h expected %h",
                   c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 20; r <= 22; r++) begin
      drive(5'(r), 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    ID_rs1 = 5'd22;
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (obs_vec() !== 22'd0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %h expected 0", obs_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(5'd17, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (obs_vec() !== exp_vec() || EX_RD !== 5'd17 || inflight_count !== 2'd1) begin
      n_fail++;
      $display("FAIL mid_reset_recover: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_propagation();
    test_g0();
    test_bubble();
    test_load_use();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_dest_pipeline_tracker

// File: doc/dest_pipeline_tracker.md
DEST_PIPELINE_TRACKER -- requirements
Module: dest_pipeline_tracker

Interface
REQ-001 The block SHALL use one clock, clk, and one reset, rst_n, which is asynchronous and active-low.
REQ-002 Ports SHALL be, in order (name  direction  width  meaning):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ID_RD  input  5  destination register of the instruction in ID.
- ID_Register_File_Enable  input  1  ID instruction writes the register file.
- ID_load_instr  input  1  ID instruction is a load.
- ID_rs1  input  5  ID source register 1.
- ID_rs2  input  5  ID source register 2.
- CU_S  input  1  hazard-unit bubble request; inject a NOP into EX.
- flush  input  1  annul the ID instruction (taken branch, annul bit).
- EX_RD, MEM_RD, WB_RD  output  5 each  destination per stage.
- EX_Register_File_Enable, MEM_Register_File_Enable, WB_Register_File_Enable  output  1 each  write-valid per stage.
- EX_load_instr  output  1  EX instruction is a load.
- load_use_stall  output  1  stall request for a load-use hazard.
- inflight_count  output  2  number of stages holding a valid write.

Function
REQ-003 Every rising edge SHALL shift WB<=MEM and MEM<=EX, copying RD, enable and load fields together.
REQ-004 EX SHALL load {ID_RD, ID_Register_File_Enable, ID_load_instr} when CU_S=0 and flush=0; otherwise EX SHALL load a bubble {0,0,0}.
REQ-005 Simultaneous CU_S=1 and flush=1 SHALL produce a single bubble; no extra cycle SHALL be lost.
REQ-006 An ID write to register 0 (%g0) SHALL enter EX with enable=0 and RD=0.
REQ-007 All stage outputs SHALL be registered, with one cycle of latency per stage: ID to WB visibility takes 3 edges.
REQ-008 inflight_count SHALL be registered and SHALL equal the number of enable bits set in the next EX/MEM/WB state (range 0..3, no wrap).
REQ-009 load_use_stall SHALL be combinational: 1 iff EX_load_instr, EX_Register_File_Enable, EX_RD!=0, and (ID_rs1==EX_RD or ID_rs2==EX_RD).
REQ-010 The block SHALL not stall its own shift; MEM and WB SHALL advance regardless of CU_S or flush.

Reset
REQ-011 While rst_n=0 all stage registers SHALL be zero: RD=0, enables=0, load=0, inflight_count=0; load_use_stall SHALL therefore be 0.
REQ-012 A reset asserted mid-operation SHALL clear all stages immediately, without waiting for a clock edge.
REQ-013 The first edge after deassertion SHALL capture ID normally.

Configuration
REQ-014 When macro LOAD_USE_STALL_EN is defined, the load flag SHALL be tracked and load_use_stall SHALL behave per REQ-009.
REQ-015 When LOAD_USE_STALL_EN is undefined, EX_load_instr and load_use_stall SHALL be constant 0, and no load-flag storage SHALL exist; ports SHALL be unchanged.

Structure
REQ-016 A shared package SHALL hold the constant REG_W=5, the constant G0=5'd0, and a stage-entry typedef {rd, we, ld}.
REQ-017 One sub-module, dest_stage_reg, SHALL be instantiated 3 times: an asynchronous-clear register with a bubble select.

Verification
REQ-018 Reset check: rst_n=0 mid-stream with all stages valid -> all outputs 0 before the next edge; inflight_count=0.
REQ-019 Propagation: ID_RD=5'd9 with enable=1 for one cycle -> EX_RD=9 at edge 1, MEM_RD=9 at edge 2, WB_RD=9 at edge 3; inflight_count sequence 1,1,1,0.
REQ-020 %g0 case: ID_RD=0 with enable=1 -> EX_Register_File_Enable=0 and inflight_count=0.
REQ-021 Bubble: CU_S=1 and flush=1 together with ID_RD=4 -> EX holds {0,0}, and MEM still receives the previous EX contents.
REQ-022 Load-use (macro on): a load to r7 is in EX and ID_rs2=7 -> load_use_stall=1; with ID_rs1=ID_rs2=6 -> load_use_stall=0; macro off -> always 0.
REQ-023 Back-to-back: writes to r1, r2, r3 on consecutive cycles -> after edge 3, EX/MEM/WB_RD = 3/2/1 and inflight_count=3.
